// File: rtl/even_odd_arbiter.sv
// -----------------------------------------------------------------------------
// even_odd_arbiter
//
// Shares a single even/odd classifier between two requesters. A round-robin
// arbiter picks one pending request, pulses that requester's grant, and one
// cycle later presents a tagged even/odd result. Saturating per-class tallies
// count every result produced.
//
// All outputs are registered. Timing of one transaction:
//   edge N   : request sampled in IDLE, operand/id latched
//   cycle N+1: grant pulse, FSM in CHECK
//   cycle N+2: res_valid pulse with res_id/res_even/res_odd, tallies updated,
//              FSM back in IDLE (so a new request can be sampled at edge N+2)
//
// Ports
//   clk_i          clock, rising edge
//   rst_n_i        synchronous reset, active low
//   cnt_clr_i      synchronous clear of both tallies (wins over an increment)
//   req0_i/data0_i requester 0 level request and operand
//   req1_i/data1_i requester 1 level request and operand
//   grant0_o       one-cycle pulse, requester 0 operand accepted
//   grant1_o       one-cycle pulse, requester 1 operand accepted
//   res_valid_o    one-cycle pulse, result fields valid
//   res_id_o       requester index of the current result
//   res_even_o     operand LSB was 0 (only while res_valid_o)
//   res_odd_o      operand LSB was 1 (only while res_valid_o)
//   even_cnt_o     saturating count of even results
//   odd_cnt_o      saturating count of odd results
//
// State table
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | waiting for a request; samples req0_i/req1_i at each edge
//   ST_CHECK | operand latched, grant visible; next edge produces the result
// -----------------------------------------------------------------------------
module even_odd_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             cnt_clr_i,
    input  logic             req0_i,
    input  logic [WIDTH-1:0] data0_i,
    input  logic             req1_i,
    input  logic [WIDTH-1:0] data1_i,
    output logic             grant0_o,
    output logic             grant1_o,
    output logic             res_valid_o,
    output logic             res_id_o,
    output logic             res_even_o,
    output logic             res_odd_o,
    output logic [CNT_W-1:0] even_cnt_o,
    output logic [CNT_W-1:0] odd_cnt_o
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CHECK = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e state_q, state_d;

    // Only the operand LSB decides the class, so that is all that is kept.
    logic             opnd_lsb_q, opnd_lsb_d;
    logic             id_q, id_d;
    logic             last_id_q, last_id_d;

    logic             grant0_q, grant0_d;
    logic             grant1_q, grant1_d;
    logic             res_valid_q, res_valid_d;
    logic             res_id_q, res_id_d;
    logic             res_even_q, res_even_d;
    logic             res_odd_q, res_odd_d;
    logic [CNT_W-1:0] even_cnt_q, even_cnt_d;
    logic [CNT_W-1:0] odd_cnt_q, odd_cnt_d;

    logic             any_req;
    logic             sel_id;
    logic             sel_lsb;

    // Upper operand bits do not influence the classification.
    logic             unused_data;
    assign unused_data = ^{data0_i[WIDTH-1:1], data1_i[WIDTH-1:1]};

    // -------------------------------------------------------------------------
    // Arbitration: a lone request wins outright; on contention the requester
    // that was not served last wins. last_id resets to 1 so requester 0 takes
    // the first contention.
    // -------------------------------------------------------------------------
    assign any_req = req0_i | req1_i;

    always_comb begin
        if (req0_i && req1_i) begin
            sel_id = ~last_id_q;
        end else begin
            sel_id = req1_i;
        end
    end

    assign sel_lsb = sel_id ? data1_i[0] : data0_i[0];

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. CHECK always returns to IDLE after one cycle, and
    // requests are ignored there, so a level request held through CHECK is only
    // seen again at the following IDLE edge as a fresh transaction.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output / datapath next values. Grants and result pulses default to 0 so
    // each is high for exactly one cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        grant0_d    = 1'b0;
        grant1_d    = 1'b0;
        res_valid_d = 1'b0;
        res_even_d  = 1'b0;
        res_odd_d   = 1'b0;
        res_id_d    = res_id_q;
        opnd_lsb_d  = opnd_lsb_q;
        id_d        = id_q;
        last_id_d   = last_id_q;
        even_cnt_d  = even_cnt_q;
        odd_cnt_d   = odd_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    id_d       = sel_id;
                    opnd_lsb_d = sel_lsb;
                    grant0_d   = ~sel_id;
                    grant1_d   = sel_id;
                end
            end
            ST_CHECK: begin
                res_valid_d = 1'b1;
                res_id_d    = id_q;
                res_even_d  = ~opnd_lsb_q;
                res_odd_d   = opnd_lsb_q;
                last_id_d   = id_q;
                if (opnd_lsb_q) begin
                    if (odd_cnt_q != CNT_MAX) begin
                        odd_cnt_d = odd_cnt_q + CNT_ONE;
                    end
                end else begin
                    if (even_cnt_q != CNT_MAX) begin
                        even_cnt_d = even_cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
            end
        endcase

        // Clear beats a same-edge increment: that result goes uncounted.
        if (cnt_clr_i) begin
            even_cnt_d = '0;
            odd_cnt_d  = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath / output registers. Reset drops any in-flight transaction, so
    // a request granted just before reset never produces a result.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            grant0_q    <= 1'b0;
            grant1_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_even_q  <= 1'b0;
            res_odd_q   <= 1'b0;
            opnd_lsb_q  <= 1'b0;
            id_q        <= 1'b0;
            last_id_q   <= 1'b1;
            even_cnt_q  <= '0;
            odd_cnt_q   <= '0;
        end else begin
            grant0_q    <= grant0_d;
            grant1_q    <= grant1_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_even_q  <= res_even_d;
            res_odd_q   <= res_odd_d;
            opnd_lsb_q  <= opnd_lsb_d;
            id_q        <= id_d;
            last_id_q   <= last_id_d;
            even_cnt_q  <= even_cnt_d;
            odd_cnt_q   <= odd_cnt_d;
        end
    end

    assign grant0_o    = grant0_q;
    assign grant1_o    = grant1_q;
    assign res_valid_o = res_valid_q;
    assign res_id_o    = res_id_q;
    assign res_even_o  = res_even_q;
    assign res_odd_o   = res_odd_q;
    assign even_cnt_o  = even_cnt_q;
    assign odd_cnt_o   = odd_cnt_q;

endmodule
